// File: rtl/prog_ctr_jmp_if.sv
// Fetch-sequencer bus: program handshake, branch decode inputs, jump LUT
// round trip and the program counter / status outputs.
interface prog_ctr_jmp_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 8
);
  logic             Start;
  logic             Halt;
  logic             Stall;
  logic             BranchEn;
  logic             CondTaken;
  logic [2:0]       JmpIdx;
  logic [2:0]       LutAddr;
  logic [7:0]       LutTarget;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Ack;
  logic [CNT_W-1:0] BranchCnt;

  // Top level / testbench side: drives decode and LUT data, observes the PC.
  modport master (
    output Start, Halt, Stall, BranchEn, CondTaken, JmpIdx, LutTarget,
    input  LutAddr, ProgCtr, Running, Ack, BranchCnt
  );

  // Sequencer side.
  modport slave (
    input  Start, Halt, Stall, BranchEn, CondTaken, JmpIdx, LutTarget,
    output LutAddr, ProgCtr, Running, Ack, BranchCnt
  );
endinterface

// File: rtl/prog_ctr_jmp.sv
// Program counter and fetch sequencer. Runs a program between a Start
// falling edge and a Halt, applying jump-LUT targets to the PC either as
// signed relative offsets or absolute addresses, and counting taken branches.
module prog_ctr_jmp #(
  parameter int PC_W     = 10,
  parameter bit REL_JUMP = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  prog_ctr_jmp_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t          state;
  logic [PC_W-1:0] jump_pc;

  // Jump index goes straight to the LUT; its answer is used this same cycle.
  assign bus.LutAddr = bus.JmpIdx;

  // Branch destination: PC plus sign-extended offset, or zero-extended target.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can hold an old value and infer a latch.
    jump_pc = '0;
    if (REL_JUMP) jump_pc = bus.ProgCtr + PC_W'(signed'(bus.LutTarget));
    else          jump_pc = PC_W'(bus.LutTarget);
  end

  // Sequencer FSM with registered PC, status flags and taken-branch counter.
  always_ff @(posedge Clk) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state         <= IDLE;
      bus.ProgCtr   <= '0;
      bus.BranchCnt <= '0;
      bus.Running   <= 1'b0;
      bus.Ack       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            state         <= ARMED;
            bus.ProgCtr   <= '0;
            bus.BranchCnt <= '0;
          end
        end

        ARMED: begin
          bus.ProgCtr   <= '0;
          bus.BranchCnt <= '0;
          if (!bus.Start) begin
            state       <= RUN;
            bus.Running <= 1'b1;
          end
        end

        RUN: begin
          if (bus.Start) begin
            // Restart: back to armed with a fresh PC and count.
            state         <= ARMED;
            bus.ProgCtr   <= '0;
            bus.BranchCnt <= '0;
            bus.Running   <= 1'b0;
          end else if (bus.Halt) begin
            // Halt outranks any branch decoded at the same PC.
            state       <= DONE;
            bus.Running <= 1'b0;
            bus.Ack     <= 1'b1;
          end else if (bus.Stall) begin
            // Multi-cycle instruction in flight: PC and count hold.
          end else if (bus.BranchEn && bus.CondTaken) begin
            bus.ProgCtr <= jump_pc;
            if (bus.BranchCnt != '1) bus.BranchCnt <= bus.BranchCnt + CNT_W'(1);
          end else begin
            bus.ProgCtr <= bus.ProgCtr + PC_W'(1);
          end
        end

        DONE: begin
          if (bus.Start) begin
            state         <= ARMED;
            bus.Ack       <= 1'b0;
            bus.ProgCtr   <= '0;
            bus.BranchCnt <= '0;
          end
        end

        default: begin
          state       <= IDLE;
          bus.Running <= 1'b0;
          bus.Ack     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_ctr_jmp.sv
// Bench for prog_ctr_jmp: one relative-jump and one absolute-jump instance
// share the same stimulus and are compared every cycle against a
// behavioural model, with directed scenarios followed by random traffic.
module tb_prog_ctr_jmp;

  localparam int PC_W  = 10;
  localparam int CNT_W = 8;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, halt, stall, branch_en, cond_taken;
  logic [2:0] jmp_idx;
  logic [7:0] lut_target;

  int checks = 0;
  int errors = 0;

  // Model state: phase, one PC per jump mode, shared branch count.
  int m_st, m_pc_rel, m_pc_abs, m_cnt;

  prog_ctr_jmp_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus_rel ();
  prog_ctr_jmp_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus_abs ();

  assign bus_rel.Start     = start;
  assign bus_rel.Halt      = halt;
  assign bus_rel.Stall     = stall;
  assign bus_rel.BranchEn  = branch_en;
  assign bus_rel.CondTaken = cond_taken;
  assign bus_rel.JmpIdx    = jmp_idx;
  assign bus_rel.LutTarget = lut_target;

  assign bus_abs.Start     = start;
  assign bus_abs.Halt      = halt;
  assign bus_abs.Stall     = stall;
  assign bus_abs.BranchEn  = branch_en;
  assign bus_abs.CondTaken = cond_taken;
  assign bus_abs.JmpIdx    = jmp_idx;
  assign bus_abs.LutTarget = lut_target;

  prog_ctr_jmp #(.PC_W(PC_W), .REL_JUMP(1'b1), .CNT_W(CNT_W)) dut_rel (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus_rel)
  );

  prog_ctr_jmp #(.PC_W(PC_W), .REL_JUMP(1'b0), .CNT_W(CNT_W)) dut_abs (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus_abs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the specified behaviour, from the inputs held this cycle.
  task automatic model_step();
    int off;
    off = int'($signed(lut_target));
    if (reset) begin
      m_st = M_IDLE; m_pc_rel = 0; m_pc_abs = 0; m_cnt = 0;
    end else if (m_st == M_IDLE) begin
      if (start) begin m_st = M_ARMED; m_pc_rel = 0; m_pc_abs = 0; m_cnt = 0; end
    end else if (m_st == M_ARMED) begin
      m_pc_rel = 0; m_pc_abs = 0; m_cnt = 0;
      if (!start) m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (start) begin
        m_st = M_ARMED; m_pc_rel = 0; m_pc_abs = 0; m_cnt = 0;
      end else if (halt) begin
        m_st = M_DONE;
      end else if (stall) begin
        m_st = M_RUN;
      end else if (branch_en && cond_taken) begin
        m_pc_rel = (m_pc_rel + off + PC_MOD) % PC_MOD;
        m_pc_abs = int'(lut_target) % PC_MOD;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else begin
        m_pc_rel = (m_pc_rel + 1) % PC_MOD;
        m_pc_abs = (m_pc_abs + 1) % PC_MOD;
      end
    end else begin
      if (start) begin m_st = M_ARMED; m_pc_rel = 0; m_pc_abs = 0; m_cnt = 0; end
    end
  endtask

  // Advance one clock and compare both instances with the model.
  task automatic step();
    @(negedge clk);
    check("lut_addr_rel", bus_rel.LutAddr, jmp_idx);
    check("lut_addr_abs", bus_abs.LutAddr, jmp_idx);
    model_step();
    @(posedge clk);
    #1;
    check("pc_rel",      bus_rel.ProgCtr,   m_pc_rel);
    check("pc_abs",      bus_abs.ProgCtr,   m_pc_abs);
    check("cnt_rel",     bus_rel.BranchCnt, m_cnt);
    check("cnt_abs",     bus_abs.BranchCnt, m_cnt);
    check("running_rel", bus_rel.Running,   m_st == M_RUN);
    check("running_abs", bus_abs.Running,   m_st == M_RUN);
    check("ack_rel",     bus_rel.Ack,       m_st == M_DONE);
    check("ack_abs",     bus_abs.Ack,       m_st == M_DONE);
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic set_branch(input logic taken, input logic [7:0] tgt);
    branch_en  = 1'b1;
    cond_taken = taken;
    lut_target = tgt;
  endtask

  task automatic clear_branch();
    branch_en  = 1'b0;
    cond_taken = 1'b0;
    lut_target = 8'h00;
  endtask

  initial begin
    m_st = M_IDLE; m_pc_rel = 0; m_pc_abs = 0; m_cnt = 0;
    reset = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
    branch_en = 1'b0; cond_taken = 1'b0; jmp_idx = 3'd0; lut_target = 8'h00;

    // Reset state.
    step();
    step();
    reset = 1'b0;
    check("rst_pc",  bus_rel.ProgCtr, 0);
    check("rst_ack", bus_rel.Ack, 0);
    check("rst_run", bus_rel.Running, 0);

    // Launch: Start held two cycles then dropped, five plain cycles.
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    step();
    check("p1_pc0", bus_rel.ProgCtr, 0);
    check("p1_run", bus_rel.Running, 1);
    for (int i = 1; i < 5; i++) begin
      step();
      check("p1_pc", bus_rel.ProgCtr, i);
    end
    check("p1_ack", bus_rel.Ack, 0);

    // Relative branch at PC 5 with offset -2, then the not-taken variant.
    step();
    check("p2_pc5", bus_rel.ProgCtr, 5);
    jmp_idx = 3'b010;
    set_branch(1'b1, 8'hFE);
    step();
    check("p2_taken_pc", bus_rel.ProgCtr, 3);
    check("p2_taken_cnt", bus_rel.BranchCnt, 1);
    check("p2_abs_pc", bus_abs.ProgCtr, 254);
    clear_branch();
    launch();
    for (int i = 0; i < 5; i++) step();
    set_branch(1'b0, 8'hFE);
    step();
    check("p2_nt_pc", bus_rel.ProgCtr, 6);
    check("p2_nt_cnt", bus_rel.BranchCnt, 0);
    clear_branch();

    // Absolute jumps, then relative wrap above max and below zero.
    launch();
    set_branch(1'b1, 8'hC8);
    step();
    check("p3_abs200", bus_abs.ProgCtr, 200);
    set_branch(1'b1, 8'h7F);
    step();
    check("p3_abs127", bus_abs.ProgCtr, 127);
    clear_branch();
    launch();
    set_branch(1'b1, 8'hFF);
    step();
    check("p3_rel1023", bus_rel.ProgCtr, 1023);
    clear_branch();
    step();
    check("p3_wrap0", bus_rel.ProgCtr, 0);
    step();
    set_branch(1'b1, 8'hFC);
    step();
    check("p3_rel1021", bus_rel.ProgCtr, 1021);
    clear_branch();

    // Halt together with a taken branch, then restart from DONE.
    launch();
    for (int i = 0; i < 9; i++) step();
    check("p4_pc9", bus_rel.ProgCtr, 9);
    halt = 1'b1;
    set_branch(1'b1, 8'h20);
    step();
    check("p4_halt_pc", bus_rel.ProgCtr, 9);
    check("p4_ack", bus_rel.Ack, 1);
    check("p4_cnt", bus_rel.BranchCnt, 0);
    halt = 1'b0;
    clear_branch();
    step();
    check("p4_frozen_pc", bus_rel.ProgCtr, 9);
    start = 1'b1;
    step();
    check("p4_rearm_ack", bus_rel.Ack, 0);
    check("p4_rearm_pc", bus_rel.ProgCtr, 0);
    start = 1'b0;
    step();

    // Stall holds a pending taken branch for three cycles.
    for (int i = 0; i < 4; i++) step();
    stall = 1'b1;
    set_branch(1'b1, 8'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      check("p5_stall_pc", bus_rel.ProgCtr, 4);
    end
    stall = 1'b0;
    step();
    check("p5_jump_pc", bus_rel.ProgCtr, 20);
    check("p5_cnt", bus_rel.BranchCnt, 1);
    clear_branch();

    // Reset mid-program, then counter saturation.
    launch();
    set_branch(1'b1, 8'h01);
    for (int i = 0; i < 5; i++) step();
    clear_branch();
    for (int i = 0; i < 32; i++) step();
    check("p6_pc37", bus_rel.ProgCtr, 37);
    check("p6_cnt5", bus_rel.BranchCnt, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("p6_rst_pc", bus_rel.ProgCtr, 0);
    check("p6_rst_cnt", bus_rel.BranchCnt, 0);
    check("p6_rst_ack", bus_rel.Ack, 0);
    step();
    check("p6_idle_run", bus_rel.Running, 0);
    launch();
    set_branch(1'b1, 8'h01);
    for (int i = 0; i < 260; i++) step();
    check("p6_sat", bus_rel.BranchCnt, 255);
    clear_branch();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 15) == 0);
      halt       = ($urandom_range(0, 31) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      branch_en  = 1'($urandom);
      cond_taken = 1'($urandom);
      jmp_idx    = 3'($urandom);
      lut_target = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_ctr_jmp.md
Name: prog_ctr_jmp

Overview:
- Program counter and fetch sequencer for the core.
- It consumes the 3-bit jump index decoded from a branch instruction and drives it to the program-specific jump lookup table as LutAddr.
- It receives the 8-bit LutTarget back and applies it to the program counter, as either an absolute address or a signed relative offset.
- It owns the Start/Ack program handshake with the testbench or top level, and counts taken branches.

Parameters:
- PC_W, 10, program counter width in bits; instruction memory depth is 2^PC_W.
- REL_JUMP, 1, 1 = LutTarget is a signed 8-bit offset added to PC; 0 = LutTarget is an absolute address, zero-extended.
- CNT_W, 8, width of the taken-branch counter.

Ports:
- Clk, input, 1, system clock; all state updates on the rising edge.
- Reset, input, 1, synchronous, active-high reset.
- Start, input, 1, high = hold and arm; the falling edge (observed while armed) launches the program.
- Halt, input, 1, decoded halt instruction at the current PC.
- Stall, input, 1, freezes PC for one cycle (multi-cycle instruction in flight).
- BranchEn, input, 1, current instruction is a conditional branch.
- CondTaken, input, 1, branch condition result from the ALU flags.
- JmpIdx, input, 3, jump index field of the branch instruction.
- LutAddr, output, 3, index driven to the jump LUT.
- LutTarget, input, 8, target or offset returned by the jump LUT, combinational same cycle.
- ProgCtr, output, PC_W, current instruction address.
- Running, output, 1, high in RUN.
- Ack, output, 1, program complete.
- BranchCnt, output, CNT_W, number of taken branches since the last launch; saturating.

Behaviour:
- Reset is synchronous, active-high, and has priority over everything.
  - State goes to IDLE.
  - ProgCtr=0, Ack=0, Running=0, BranchCnt=0.
  - Reset asserted mid-program aborts immediately with the same values.
- LutAddr = JmpIdx, purely combinational and in every state. The LUT round trip is zero-latency; the target is used in the same cycle.
- States: IDLE, ARMED, RUN, DONE. All outputs are registered except LutAddr.
- IDLE: Start=1 -> ARMED.
- ARMED:
  - ProgCtr held at 0 and BranchCnt cleared to 0.
  - Start=0 -> RUN. ProgCtr is still 0 on the first RUN cycle.
- RUN (Running=1), priority order evaluated each cycle:
  1. Start=1 -> ARMED, ProgCtr<=0 (restart).
  2. Halt=1 -> DONE, ProgCtr holds.
  3. Stall=1 -> hold, no branch evaluated.
  4. BranchEn & CondTaken -> jump; BranchCnt+1, saturating at all-ones.
  5. Otherwise -> ProgCtr+1.
- Jump arithmetic:
  - REL_JUMP=1: ProgCtr <= ProgCtr + sign_extend(LutTarget) modulo 2^PC_W; wraps both below 0 and above max.
  - REL_JUMP=0: ProgCtr <= zero_extend(LutTarget); for PC_W<8, the upper bits are truncated.
- BranchEn with CondTaken=0 -> ProgCtr+1; not counted.
- Sequential increment wraps from 2^PC_W-1 to 0.
- DONE:
  - Ack=1, Running=0; ProgCtr and BranchCnt frozen.
  - Start=1 -> ARMED; Ack drops on entry to ARMED.
- Ack is high only in DONE.
- Halt, Stall and BranchEn are ignored outside RUN.
- Halt and a taken branch in the same cycle: Halt wins, no jump, no count.

Test Plan:
1. Reset, Start=1 for 2 cycles, then Start=0, 5 plain cycles -> ProgCtr 0,1,2,3,4; Running=1; Ack=0.
2. REL_JUMP=1, ProgCtr=5, BranchEn=1, CondTaken=1, JmpIdx=3'b010, LUT returns 8'hFE -> LutAddr=2; next ProgCtr=3; BranchCnt=1. Same stimulus with CondTaken=0 -> ProgCtr=6, BranchCnt=0.
3. REL_JUMP=0, PC_W=10, LutTarget=8'h7F at ProgCtr=200 -> ProgCtr=127. Separately, REL_JUMP=1 at ProgCtr=1023 with a plain step -> 0, and at ProgCtr=1 with offset 8'hFC -> 1021.
4. Halt at ProgCtr=9 together with a taken branch -> ProgCtr stays 9, Ack=1 next cycle, BranchCnt unchanged. Start=1 -> ARMED, Ack=0, ProgCtr=0.
5. Stall=1 for 3 cycles at ProgCtr=4 with a taken branch pending -> ProgCtr 4,4,4, then jump after Stall drops; BranchCnt increments once.
6. Reset mid-RUN at ProgCtr=37 with BranchCnt=5 -> next edge: IDLE, ProgCtr=0, BranchCnt=0, Ack=0. Also force 260 taken branches -> BranchCnt saturates at 255.
